pipe_flow_ctrl: RTL and testbench
=================================

// Module: pipe_flow_ctrl
// PURPOSE
//  Pipeline flow sequencer for the 16-bit 5-stage core. Sits beside the decode-stage branch
//  hazard unit and consumes its kill/target together with load-use and instruction-memory status.
//  Drives PC enable/select, IF/ID write/flush and the ID/EX bubble, and holds a pending redirect
//  across instruction-memory wait cycles.
// PARAMETERS
//  PC_W            16  PC / target width
//  LU_STALL_CYCLES 1   decode-freeze cycles per load-use hit (legal 1..3)
//  CNT_W           16  width of perf counters (PERF_CNT_EN only)
// PORTS
//  clk            in   1     core clock, rising edge
//  reset          in   1     synchronous, active-high
//  kill           in   1     decode-stage taken branch/JMP/CALL/RET/FOR
//  target_pc      in   PC_W  redirect target, valid with kill
//  load_use       in   1     decode operand depends on load in EX
//  imem_ready     in   1     instruction memory returns fetch this cycle
//  pc_write       out  1     PC register enable
//  pc_sel         out  1     0 = PC+1, 1 = redirect_pc
//  redirect_pc    out  PC_W  target to load into PC when pc_sel=1
//  if_id_write    out  1     IF/ID register enable
//  if_id_flush    out  1     load NOP into IF/ID (dominates if_id_write)
//  id_ex_bubble   out  1     load NOP into ID/EX
//  redirect_pend  out  1     registered: captured target awaiting fetch
//  redirect_cnt   out  CNT_W taken redirects (PERF_CNT_EN)
//  stall_cnt      out  CNT_W load-use stall cycles (PERF_CNT_EN)
// BEHAVIOUR
//  States: RUN, LU_STALL, WAIT_FETCH. Outputs Mealy on state+inputs; target_q, lu_cnt registered.
//  Reset: state=RUN, target_q=0, lu_cnt=0, redirect_pend=0. While reset=1: pc_write=0,
//   pc_sel=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1. Reset mid-stall or mid-redirect
//   discards all pending work.
//  RUN, priority load_use > kill > !imem_ready > normal:
//   load_use=1: pc_write=0, if_id_write=0, id_ex_bubble=1; kill ignored this cycle (forwarded
//    operands invalid); lu_cnt<=LU_STALL_CYCLES-1; ->LU_STALL if LU_STALL_CYCLES>1, else stay RUN.
//   kill=1, imem_ready=1: pc_sel=1, pc_write=1, redirect_pc=target_pc, if_id_flush=1; zero-cycle
//    redirect, exactly one wrong-path slot flushed; stay RUN.
//   kill=1, imem_ready=0: target_q<=target_pc, if_id_flush=1, pc_write=0, ->WAIT_FETCH.
//   imem_ready=0 (no kill): pc_write=0, if_id_flush=1 (bubble into decode).
//   else: pc_write=1, pc_sel=0, if_id_write=1.
//  LU_STALL: same freeze outputs as load_use hit; lu_cnt decrements each cycle;
//   ->RUN when lu_cnt==1 (total freeze = LU_STALL_CYCLES). kill and load_use ignored.
//  WAIT_FETCH: redirect_pend=1, redirect_pc=target_q, if_id_flush=1. On imem_ready=1:
//   pc_sel=1, pc_write=1, ->RUN; otherwise hold. kill/load_use ignored (decode holds NOPs).
//  redirect_pc = target_pc in RUN, target_q otherwise; pc_sel=0 whenever pc_write=0.
// CONFIGURATION
//  PERF_CNT_EN defined: redirect_cnt +1 per cycle with pc_sel=1 & pc_write=1;
//   stall_cnt +1 per load-use freeze cycle. Both saturate at all-ones and clear on reset.
//  PERF_CNT_EN undefined: counters not built; redirect_cnt/stall_cnt tied to 0.
// TESTING
//  kill=1, target_pc=16'h0040, imem_ready=1 -> same cycle pc_sel=1, pc_write=1, if_id_flush=1,
//   redirect_pc=0040
//  load_use=1 and kill=1 same cycle, LU_STALL_CYCLES=2 -> 2 cycles pc_write=0, id_ex_bubble=1;
//   no redirect
//  kill target 16'h0100 with imem_ready=0 for 3 cycles -> redirect_pend=1 x3; on ready,
//   pc_sel=1 and redirect_pc=0100
//  reset asserted during WAIT_FETCH -> next cycle state RUN, redirect_pend=0, target_q=0
//  PERF_CNT_EN, CNT_W=4: 20 redirects -> redirect_cnt=4'hF (saturated); undefined -> 0

Source files
------------

// File: rtl/pipe_flow_ctrl_if.sv
// ============================================================================
// Module   : pipe_flow_ctrl_if
// Brief    : Hazard/fetch status in, PC and pipeline-register controls out,
//            for the pipeline flow sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_flow_ctrl_if #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
);
    logic             kill;
    logic [PC_W-1:0]  target_pc;
    logic             load_use;
    logic             imem_ready;
    logic             pc_write;
    logic             pc_sel;
    logic [PC_W-1:0]  redirect_pc;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             redirect_pend;
    logic [CNT_W-1:0] redirect_cnt;
    logic [CNT_W-1:0] stall_cnt;

    // Master: hazard unit / fetch side driving status into the sequencer.
    modport master (
        output kill, target_pc, load_use, imem_ready,
        input  pc_write, pc_sel, redirect_pc, if_id_write, if_id_flush,
               id_ex_bubble, redirect_pend, redirect_cnt, stall_cnt
    );

    // Slave: the flow sequencer itself.
    modport slave (
        input  kill, target_pc, load_use, imem_ready,
        output pc_write, pc_sel, redirect_pc, if_id_write, if_id_flush,
               id_ex_bubble, redirect_pend, redirect_cnt, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipe_flow_ctrl.sv
// ============================================================================
// Module   : pipe_flow_ctrl
// Brief    : PC / IF-ID / ID-EX flow sequencer; holds a redirect across
//            instruction-memory wait cycles. Optional macro PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_flow_ctrl #(
    parameter int PC_W            = 16,
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pipe_flow_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LU_STALL   = 2'd1,
        ST_WAIT_FETCH = 2'd2
    } state_t;

    localparam logic [1:0] c_lu_init = 2'(LU_STALL_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_target_q;
    logic [PC_W-1:0] w_target_nxt;
    logic [1:0]      r_lu_cnt;
    logic [1:0]      w_lu_cnt_nxt;
    logic            r_redirect_pend;

    logic            w_pc_write;
    logic            w_pc_sel;
    logic [PC_W-1:0] w_redirect_pc;
    logic            w_if_id_write;
    logic            w_if_id_flush;
    logic            w_id_ex_bubble;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_RUN;
            r_target_q      <= '0;
            r_lu_cnt        <= 2'd0;
            r_redirect_pend <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_target_q      <= w_target_nxt;
            r_lu_cnt        <= w_lu_cnt_nxt;
            r_redirect_pend <= (w_state_nxt == ST_WAIT_FETCH);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target_q;
        w_lu_cnt_nxt   = r_lu_cnt;
        w_pc_write     = 1'b0;
        w_pc_sel       = 1'b0;
        w_if_id_write  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_redirect_pc  = (r_state == ST_RUN) ? bus.target_pc : r_target_q;

        if (reset) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // Load-use wins over kill: the branch resolved on stale operands.
                    if (bus.load_use) begin
                        w_id_ex_bubble = 1'b1;
                        w_lu_cnt_nxt   = c_lu_init;
                        if (LU_STALL_CYCLES > 1) begin
                            w_state_nxt = ST_LU_STALL;
                        end
                    end else if (bus.kill) begin
                        w_if_id_flush = 1'b1;
                        if (bus.imem_ready) begin
                            w_pc_write = 1'b1;
                            w_pc_sel   = 1'b1;
                        end else begin
                            w_target_nxt = bus.target_pc;
                            w_state_nxt  = ST_WAIT_FETCH;
                        end
                    end else if (!bus.imem_ready) begin
                        w_if_id_flush = 1'b1;
                    end else begin
                        w_pc_write    = 1'b1;
                        w_if_id_write = 1'b1;
                    end
                end
                ST_LU_STALL: begin
                    w_id_ex_bubble = 1'b1;
                    w_lu_cnt_nxt   = r_lu_cnt - 2'd1;
                    if (r_lu_cnt == 2'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_WAIT_FETCH: begin
                    w_if_id_flush = 1'b1;
                    if (bus.imem_ready) begin
                        w_pc_write  = 1'b1;
                        w_pc_sel    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign bus.pc_write      = w_pc_write;
    assign bus.pc_sel        = w_pc_sel;
    assign bus.redirect_pc   = w_redirect_pc;
    assign bus.if_id_write   = w_if_id_write;
    assign bus.if_id_flush   = w_if_id_flush;
    assign bus.id_ex_bubble  = w_id_ex_bubble;
    assign bus.redirect_pend = r_redirect_pend;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_redirect_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_lu_freeze;

    assign w_lu_freeze = !reset &&
                         ((r_state == ST_LU_STALL) || ((r_state == ST_RUN) && bus.load_use));

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_pc_sel && w_pc_write && (r_redirect_cnt != {CNT_W{1'b1}})) begin
                r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
            end
            if (w_lu_freeze && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.redirect_cnt = r_redirect_cnt;
    assign bus.stall_cnt    = r_stall_cnt;
`else
    assign bus.redirect_cnt = {CNT_W{1'b0}};
    assign bus.stall_cnt    = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_flow_ctrl.sv
// ============================================================================
// Module   : tb_pipe_flow_ctrl
// Brief    : Directed vector table plus reset/counter sequences for
//            pipe_flow_ctrl (LU_STALL_CYCLES=2, CNT_W=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_flow_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pipe_flow_ctrl_if #(.PC_W(16), .CNT_W(4)) bus ();

    pipe_flow_ctrl #(
        .PC_W            (16),
        .LU_STALL_CYCLES (2),
        .CNT_W           (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        kill;
        logic [15:0] tpc;
        logic        lu;
        logic        rdy;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs [16];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Expected output word: {pc_write, pc_sel, redirect_pc, if_id_write, if_id_flush, id_ex_bubble, redirect_pend}
    function automatic logic [21:0] E(input logic pw, input logic ps, input logic [15:0] rpc,
                                      input logic ifw, input logic fl, input logic bub,
                                      input logic pend);
        return {pw, ps, rpc, ifw, fl, bub, pend};
    endfunction

    function automatic logic [3:0] ecnt(input int v);
`ifdef PERF_CNT_EN
        return (v > 15) ? 4'hF : 4'(v);
`else
        return (v < 0) ? 4'hF : 4'h0;
`endif
    endfunction

    function automatic logic [21:0] outs();
        return {bus.pc_write, bus.pc_sel, bus.redirect_pc, bus.if_id_write,
                bus.if_id_flush, bus.id_ex_bubble, bus.redirect_pend};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic k, input logic [15:0] t, input logic lu, input logic r);
        bus.kill       = k;
        bus.target_pc  = t;
        bus.load_use   = lu;
        bus.imem_ready = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 16'h1234, 1'b0, 1'b1, E(1, 0, 16'h1234, 1, 0, 0, 0)};
        vecs[1]  = '{1'b0, 16'h1234, 1'b0, 1'b0, E(0, 0, 16'h1234, 0, 1, 0, 0)};
        vecs[2]  = '{1'b1, 16'h0040, 1'b0, 1'b1, E(1, 1, 16'h0040, 0, 1, 0, 0)};
        vecs[3]  = '{1'b1, 16'h0200, 1'b1, 1'b1, E(0, 0, 16'h0200, 0, 0, 1, 0)};
        vecs[4]  = '{1'b1, 16'h0300, 1'b1, 1'b1, E(0, 0, 16'h0000, 0, 0, 1, 0)};
        vecs[5]  = '{1'b0, 16'h0005, 1'b0, 1'b1, E(1, 0, 16'h0005, 1, 0, 0, 0)};
        vecs[6]  = '{1'b1, 16'h0100, 1'b0, 1'b0, E(0, 0, 16'h0100, 0, 1, 0, 0)};
        vecs[7]  = '{1'b1, 16'h0999, 1'b0, 1'b0, E(0, 0, 16'h0100, 0, 1, 0, 1)};
        vecs[8]  = '{1'b0, 16'h0999, 1'b1, 1'b0, E(0, 0, 16'h0100, 0, 1, 0, 1)};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, E(0, 0, 16'h0100, 0, 1, 0, 1)};
        vecs[10] = '{1'b0, 16'h0777, 1'b0, 1'b1, E(1, 1, 16'h0100, 0, 1, 0, 1)};
        vecs[11] = '{1'b0, 16'h0ABC, 1'b0, 1'b1, E(1, 0, 16'h0ABC, 1, 0, 0, 0)};
        vecs[12] = '{1'b0, 16'h0ABC, 1'b1, 1'b1, E(0, 0, 16'h0ABC, 0, 0, 1, 0)};
        vecs[13] = '{1'b0, 16'h0055, 1'b0, 1'b0, E(0, 0, 16'h0100, 0, 0, 1, 0)};
        vecs[14] = '{1'b1, 16'h0066, 1'b0, 1'b1, E(1, 1, 16'h0066, 0, 1, 0, 0)};
        vecs[15] = '{1'b1, 16'h0F00, 1'b0, 1'b0, E(0, 0, 16'h0F00, 0, 1, 0, 0)};

        // Reset state: outputs forced while reset is high, pend clear after the edge.
        drive(1'b1, 16'hBEEF, 1'b0, 1'b1);
        #3;
        chk("reset_outputs", {27'd0, bus.pc_write, bus.pc_sel, bus.if_id_write,
                              bus.if_id_flush, bus.id_ex_bubble}, 32'b00011);
        next_cycle();
        next_cycle();
        chk("reset_pend", {31'd0, bus.redirect_pend}, 32'd0);
        chk("reset_redirect_cnt", {28'd0, bus.redirect_cnt}, {28'd0, ecnt(0)});
        chk("reset_stall_cnt", {28'd0, bus.stall_cnt}, {28'd0, ecnt(0)});
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].kill, vecs[i].tpc, vecs[i].lu, vecs[i].rdy);
            #3;
            chk($sformatf("vec%0d", i), {10'd0, outs()}, {10'd0, vecs[i].exp});
            next_cycle();
        end

        chk("table_redirect_cnt", {28'd0, bus.redirect_cnt}, {28'd0, ecnt(3)});
        chk("table_stall_cnt", {28'd0, bus.stall_cnt}, {28'd0, ecnt(4)});

        // Reset while waiting for fetch: pending redirect and captured target discarded.
        reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        #3;
        chk("wf_reset_outputs", {27'd0, bus.pc_write, bus.pc_sel, bus.if_id_write,
                                 bus.if_id_flush, bus.id_ex_bubble}, 32'b00011);
        chk("wf_reset_pend_before_edge", {31'd0, bus.redirect_pend}, 32'd1);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 16'h0123, 1'b0, 1'b1);
        #3;
        chk("post_reset_run", {10'd0, outs()}, {10'd0, E(1, 0, 16'h0123, 1, 0, 0, 0)});
        chk("post_reset_redirect_cnt", {28'd0, bus.redirect_cnt}, {28'd0, ecnt(0)});
        next_cycle();
        drive(1'b1, 16'h0456, 1'b1, 1'b1);
        #3;
        chk("post_reset_lu_hit", {10'd0, outs()}, {10'd0, E(0, 0, 16'h0456, 0, 0, 1, 0)});
        next_cycle();
        drive(1'b0, 16'h0789, 1'b0, 1'b1);
        #3;
        chk("post_reset_target_q", {10'd0, outs()}, {10'd0, E(0, 0, 16'h0000, 0, 0, 1, 0)});
        next_cycle();
        chk("post_reset_stall_cnt", {28'd0, bus.stall_cnt}, {28'd0, ecnt(2)});

        // Twenty back-to-back zero-cycle redirects saturate a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'(16'h2000 + i), 1'b0, 1'b1);
            next_cycle();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        #3;
        chk("redirect_cnt_saturate", {28'd0, bus.redirect_cnt}, {28'd0, ecnt(20)});
        chk("stall_cnt_hold", {28'd0, bus.stall_cnt}, {28'd0, ecnt(2)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
